pl_mem_lsu: RTL
===============

Name: pl_mem_lsu

Overview:
- Memory-stage load/store unit; the consumer of the execute|memory pipeline register outputs.
- Takes the M-stage address, store data, funct3 and control, and drives a variable-latency data-memory request/ready handshake.
- Generates byte enables and replicated store data, and returns aligned, sign- or zero-extended load data to writeback.
- Holds the pipeline through StallM, which feeds the pipeline registers' active-high hold input (en).

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store source (rs2)
- funct3M  in  3  access size/sign
- ResultSrcM  in  2  2'b01 = load
- MemWriteM  in  1  store
- ReadDataM  out  32  extended load data
- StallM  out  1  hold for all upstream pipeline registers
- AccessFaultM  out  1  misaligned or illegal-funct3 access, suppressed
- BusErrM  out  1  one-cycle pulse on timeout abort
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_addr  out  ADDR_W  word-aligned address, [1:0]=0
- dmem_wdata  out  32  store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted/complete
- dmem_rdata  in  32  read word, valid while dmem_ready=1

Behaviour:
- access = MemWriteM | (ResultSrcM==2'b01).
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- fault = access & (illegal funct3 | halfword with addr[0]=1 | word with addr[1:0]!=0).
- FSM states IDLE, BUSY, DONE. Reset value is IDLE.
- IDLE:
  - If access & !fault: StallM=1 combinationally. Latch word address, wdata, be, we, funct3 and addr[1:0]. Go to BUSY.
  - If fault: AccessFaultM=1 combinationally, StallM=0, no request, ReadDataM=0, stay in IDLE.
  - No access: StallM=0, stay in IDLE.
- BUSY:
  - dmem_req=1; latched fields drive the dmem_* outputs, stable until accepted.
  - StallM=1.
  - On dmem_ready: capture dmem_rdata (loads), go to DONE.
- DONE:
  - StallM=0. ReadDataM is valid from the captured register.
  - Go unconditionally to IDLE. No new access starts in DONE, so the held instruction is not reissued.
- Latency: minimum 3 cycles in M (IDLE, BUSY with ready, DONE); each extra wait cycle adds 1.
- Store data:
  - SB: {4{WriteDataM[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: {2{WriteDataM[15:0]}}, be = 4'b0011 << {addr[1],1'b0}.
  - SW: data as is, be = 4'b1111.
- Load extract: byte/half selected by the latched offset from the captured word. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- dmem_be is 4'b1111 for loads.
- ReadDataM outside DONE is 0.
- Reset mid-BUSY: drop dmem_req at once, state=IDLE, all outputs 0, captured data cleared.
- Outputs at reset: all outputs 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With it:
  - A counter is cleared on BUSY entry and increments each BUSY cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, pulse BusErrM for 1 cycle, force captured data to 0, go to DONE.
  - dmem_ready in the same cycle as the limit wins (normal completion).
- Without it: BUSY waits indefinitely, and BusErrM is tied to 0.

Test Plan:
- LW, addr 0x100, ready in first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr=0x100, be=1111, StallM high for 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- SB, addr 0x103, WriteDataM=0x000000A5 -> dmem_we=1, be=1000, wdata=0xA5A5A5A5, ready after 3 wait cycles -> StallM high for 5 cycles total.
- LB/LBU, addr 0x202, rdata 0x12F0_3456 -> LB gives 0xFFFFFFF0, LBU gives 0x000000F0; LH addr 0x202 gives 0x000012F0.
- LW at 0x102, and funct3=011 load -> AccessFaultM=1, dmem_req never asserted, StallM=0.
- rst_n low during BUSY -> dmem_req=0 asynchronously; after release the next LW completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready held 0 -> BusErrM pulses after 4 BUSY cycles, ReadDataM=0, StallM released the next cycle.

Source files
------------

// File: rtl/pl_mem_lsu.sv
// pl_mem_lsu: memory-stage load/store unit driving a variable-latency data-memory handshake
// Ports: M-stage inputs ALUResultM/WriteDataM/funct3M/ResultSrcM/MemWriteM;
//   pipeline outputs ReadDataM (extended load data), StallM (hold), AccessFaultM, BusErrM;
//   memory side dmem_req/we/addr/wdata/be out, dmem_ready/rdata in.
// Optional: define LSU_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES without dmem_ready.
module pl_mem_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [2:0]        funct3M,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              AccessFaultM,
  output logic              BusErrM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, sdata, ext;
  logic [3:0] be_q, be_d, sbe;
  logic we_q, we_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic access, legal, mis, fault, go, idle, busy, expire;
  logic [7:0] bsel;
  logic [15:0] hsel;
  always_comb begin
    access = MemWriteM | (ResultSrcM == 2'b01);
    // funct3[1:0]==11 is never legal; unsigned forms (1xx) exist only for byte/half loads
    legal = (funct3M[1:0] != 2'b11) & (!funct3M[2] | (!MemWriteM & !funct3M[1]));
    mis = (funct3M[1:0] == 2'b01 & ALUResultM[0]) | (funct3M[1:0] == 2'b10 & ALUResultM[1:0] != 2'b00);
    fault = access & (!legal | mis);
    go = access & !fault;
    sdata = funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
            funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    sbe = !MemWriteM ? 4'hF :
          funct3M[1:0] == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
          funct3M[1:0] == 2'b01 ? 4'b0011 << {ALUResultM[1], 1'b0} : 4'hF;
    // extraction runs on the live dmem word so the captured register already holds the final value
    bsel = dmem_rdata[{off_q, 3'b000} +: 8];
    hsel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ext = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] & bsel[7]}}, bsel} :
          f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] & hsel[15]}}, hsel} : dmem_rdata;
  end
  assign idle = state_q == IDLE;
  assign busy = state_q == BUSY;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q;
  // ready on the limit cycle wins because expire requires !dmem_ready
  assign expire = busy & !dmem_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (busy & !dmem_ready) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= expire;
    end
  assign BusErrM = err_q;
`else
  assign expire = 1'b0;
  assign BusErrM = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    we_d = we_q;
    f3_d = f3_q;
    off_d = off_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = BUSY;
        addr_d = {ALUResultM[ADDR_W-1:2], 2'b00};
        wdata_d = MemWriteM ? sdata : '0;
        be_d = sbe;
        we_d = MemWriteM;
        f3_d = funct3M;
        off_d = ALUResultM[1:0];
      end
      BUSY: if (dmem_ready | expire) begin
        state_d = DONE;
        rdata_d = (dmem_ready & !we_q) ? ext : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      we_q <= we_d;
      f3_q <= f3_d;
      off_q <= off_d;
      rdata_q <= rdata_d;
    end
  // the IDLE-cycle outputs are combinational on the inputs, so gate them to keep reset outputs at 0
  assign StallM = rst_n & (busy | (idle & go));
  assign AccessFaultM = rst_n & idle & fault;
  assign dmem_req = busy;
  assign dmem_we = busy & we_q;
  assign dmem_addr = busy ? addr_q : '0;
  assign dmem_wdata = busy ? wdata_q : '0;
  assign dmem_be = busy ? be_q : '0;
  assign ReadDataM = state_q == DONE ? rdata_q : '0;
endmodule
